// File: rtl/lynx_tape_player.sv
// rtl/lynx_tape_player.sv - plays a TAP image from buffer RAM as a square-wave EAR signal
// Optional feature macro: TAPE_MOTOR_EN (motor relay freezes playback while off)
module lynx_tape_player #(
  parameter logic [15:0] HALF0  = 16'd208,
  parameter logic [15:0] HALF1  = 16'd416,
  parameter logic [15:0] LEADER = 16'd768
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        start,
  input  logic        stop,
  input  logic        busy_dl,
  input  logic        motor,
  input  logic [15:0] tap_size,
  output logic        rd_req,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  input  logic        rd_ack,
  output logic        ear,
  output logic        playing,
  output logic        done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEADER = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_BITHI  = 3'd3;
  localparam logic [2:0] S_BITLO  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state;
  logic [15:0] half_cnt;
  logic [15:0] leader_cnt;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        armed;
  logic        ack_pend;
  logic        run;
  logic [15:0] half_len;
  logic        half_end;

  assign half_len = (state == S_LEADER || !shreg[7]) ? HALF0 : HALF1;
  assign half_end = ce && (half_cnt == half_len - 16'd1);
  assign playing  = (state != S_IDLE) && (state != S_DONE);

`ifdef TAPE_MOTOR_EN
  assign run = motor;
`else
  logic unused_motor;
  assign unused_motor = motor;
  assign run = 1'b1;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rd_req     <= 1'b0;
      rd_addr    <= 16'd0;
      ear        <= 1'b0;
      done       <= 1'b0;
      half_cnt   <= 16'd0;
      leader_cnt <= 16'd0;
      shreg      <= 8'd0;
      bit_idx    <= 3'd0;
      armed      <= 1'b0;
      ack_pend   <= 1'b0;
    end else begin
      // armed blocks a start arriving in the first cycle after reset release
      armed <= 1'b1;
      done  <= 1'b0;
      if (stop || busy_dl) begin
        state    <= S_IDLE;
        rd_req   <= 1'b0;
        ear      <= 1'b0;
        ack_pend <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && armed) begin
              rd_addr    <= 16'd0;
              half_cnt   <= 16'd0;
              leader_cnt <= 16'd0;
              bit_idx    <= 3'd7;
              if (tap_size == 16'd0) begin
                state <= S_DONE;
                ear   <= 1'b0;
              end else if (LEADER == 16'd0) begin
                state  <= S_FETCH;
                rd_req <= 1'b1;
                ear    <= 1'b0;
              end else begin
                state <= S_LEADER;
                ear   <= 1'b1;
              end
            end
          end
          S_LEADER: begin
            if (run && half_end) begin
              half_cnt <= 16'd0;
              if (ear) begin
                ear <= 1'b0;
              end else if (leader_cnt == LEADER - 16'd1) begin
                state  <= S_FETCH;
                rd_req <= 1'b1;
              end else begin
                leader_cnt <= leader_cnt + 16'd1;
                ear        <= 1'b1;
              end
            end else if (run && ce) begin
              half_cnt <= half_cnt + 16'd1;
            end
          end
          S_FETCH: begin
            // a byte acked while the motor is off is kept until playback resumes
            if (rd_ack) begin
              shreg  <= rd_data;
              rd_req <= 1'b0;
            end
            if (run && (rd_ack || ack_pend)) begin
              state    <= S_BITHI;
              ear      <= 1'b1;
              half_cnt <= 16'd0;
              bit_idx  <= 3'd7;
              ack_pend <= 1'b0;
            end else if (rd_ack) begin
              ack_pend <= 1'b1;
            end
          end
          S_BITHI: begin
            if (run && half_end) begin
              half_cnt <= 16'd0;
              ear      <= 1'b0;
              state    <= S_BITLO;
            end else if (run && ce) begin
              half_cnt <= half_cnt + 16'd1;
            end
          end
          S_BITLO: begin
            if (run && half_end) begin
              half_cnt <= 16'd0;
              if (bit_idx == 3'd0) begin
                if (rd_addr == tap_size - 16'd1) begin
                  state <= S_DONE;
                end else begin
                  rd_addr <= rd_addr + 16'd1;
                  rd_req  <= 1'b1;
                  state   <= S_FETCH;
                end
              end else begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_idx <= bit_idx - 3'd1;
                ear     <= 1'b1;
                state   <= S_BITHI;
              end
            end else if (run && ce) begin
              half_cnt <= half_cnt + 16'd1;
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            ear   <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lynx_tape_player.sv
// tb/tb_lynx_tape_player.sv - directed self-checking bench for lynx_tape_player
module tb_lynx_tape_player;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy_dl = 1'b0;
  logic        motor;
  logic [15:0] tap_size = 16'd0;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic        rd_ack = 1'b0;
  logic        ear;
  logic        playing;
  logic        done;

  logic [7:0] mem [0:15];
  int ack_delay = 0;
  int wait_cnt = 0;
  int ce_mode = 0;
  int hi_run = 0;
  int done_cnt = 0;
  int hi_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int bad_req, bad_addr, bad_ear;
  logic [15:0] addr0;

  int exp1[11] = '{2, 2, 2, 4, 2, 4, 2, 2, 4, 2, 4};
  int exp2[19] = '{2, 2, 2, 2, 2, 4, 4, 4, 4, 2, 2, 4, 4, 2, 2, 2, 2, 4, 4};
  int exp5[7]  = '{4, 4, 4, 4, 4, 4, 8};

  always #5 clk_sys = ~clk_sys;

  lynx_tape_player #(.HALF0(16'd2), .HALF1(16'd4), .LEADER(16'd3)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .start   (start),
    .stop    (stop),
    .busy_dl (busy_dl),
    .motor   (motor),
    .tap_size(tap_size),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_ack  (rd_ack),
    .ear     (ear),
    .playing (playing),
    .done    (done)
  );

  // ear-high width recorder and done pulse counter
  always @(negedge clk_sys) begin
    if (done) done_cnt++;
    if (ear) hi_run++;
    else if (hi_run > 0) begin
      hi_q.push_back(hi_run);
      hi_run = 0;
    end
  end

  // buffer RAM: acks ack_delay clocks after the request is seen
  always @(negedge clk_sys) begin
    rd_ack = 1'b0;
    if (!rd_req) wait_cnt = 0;
    else if (wait_cnt == ack_delay) begin
      rd_ack   = 1'b1;
      rd_data  = mem[rd_addr[3:0]];
      wait_cnt = 0;
    end else wait_cnt++;
  end

  always @(negedge clk_sys) ce = (ce_mode != 0) ? ~ce : 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_mon();
    hi_q.delete();
    hi_run = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int i = 0;
    while (!done && i < bound) begin
      tick(1);
      i++;
    end
    check_eq(tag, done, 1'b1);
  endtask

  task automatic wait_req(input string tag, input int bound);
    int i = 0;
    while (!rd_req && i < bound) begin
      tick(1);
      i++;
    end
    check_eq(tag, rd_req, 1'b1);
  endtask

  task automatic wait_addr_hi(input string tag, input logic [15:0] a, input int bound);
    int i = 0;
    while (!(rd_addr == a && ear && playing) && i < bound) begin
      tick(1);
      i++;
    end
    check_eq(tag, {rd_addr, ear}, {a, 1'b1});
  endtask

  initial begin
`ifdef TAPE_MOTOR_EN
    motor = 1'b1;
`else
    motor = 1'b0;
`endif
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    tick(3);
    check_eq("rst_ear", ear, 1'b0);
    check_eq("rst_rd_req", rd_req, 1'b0);
    check_eq("rst_rd_addr", rd_addr, 16'd0);
    check_eq("rst_playing", playing, 1'b0);
    check_eq("rst_done", done, 1'b0);

    // start in the release cycle must be ignored
    tap_size = 16'd1;
    reset_n = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_eq("release_start_ignored", playing, 1'b0);
    tick(2);

    // short image, byte A5
    mem[0] = 8'hA5;
    tap_size = 16'd1;
    ack_delay = 0;
    clear_mon();
    pulse_start();
    check_eq("t1_playing", playing, 1'b1);
    wait_done("t1_done", 200);
    tick(4);
    check_eq("t1_done_cnt", done_cnt, 1);
    check_eq("t1_pulses", hi_q.size(), 11);
    for (int i = 0; i < 11; i++) check_eq($sformatf("t1_hi%0d", i), hi_q[i], exp1[i]);
    check_eq("t1_idle", playing, 1'b0);

    // fetch handshake with a slow RAM, two bytes
    mem[0] = 8'h3C;
    mem[1] = 8'hC3;
    tap_size = 16'd2;
    ack_delay = 10;
    clear_mon();
    pulse_start();
    wait_req("t2_req_seen", 100);
    addr0 = rd_addr;
    bad_req = 0; bad_addr = 0; bad_ear = 0;
    for (int i = 0; i < 10; i++) begin
      if (!rd_req) bad_req++;
      if (rd_addr != addr0) bad_addr++;
      if (ear) bad_ear++;
      tick(1);
    end
    check_eq("t2_req_held", bad_req, 0);
    check_eq("t2_addr_stable", bad_addr, 0);
    check_eq("t2_ear_low", bad_ear, 0);
    tick(1);
    check_eq("t2_req_dropped", rd_req, 1'b0);
    wait_done("t2_done", 500);
    tick(4);
    check_eq("t2_done_cnt", done_cnt, 1);
    check_eq("t2_pulses", hi_q.size(), 19);
    for (int i = 0; i < 19; i++) check_eq($sformatf("t2_hi%0d", i), hi_q[i], exp2[i]);

    // abort in BITHI of byte 2 of 4
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    tap_size = 16'd4;
    ack_delay = 0;
    clear_mon();
    pulse_start();
    wait_addr_hi("t3_in_byte2", 16'd1, 400);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check_eq("t3_stop_state", {ear, rd_req, playing}, 3'b000);
    tick(20);
    check_eq("t3_no_done", done_cnt, 0);
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    check_eq("t3_stop_prio", playing, 1'b0);
    pulse_start();
    wait_req("t3_restart_req", 100);
    check_eq("t3_restart_addr", rd_addr, 16'd0);
    wait_done("t3_done", 1000);
    tick(4);
    check_eq("t3_done_cnt", done_cnt, 1);

    // empty image and busy download
    tap_size = 16'd0;
    clear_mon();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_eq("t4_done_early", done, 1'b0);
    tick(1);
    check_eq("t4_done_pulse", done, 1'b1);
    tick(1);
    check_eq("t4_done_once", {done, ear}, 2'b00);
    check_eq("t4_ear_quiet", hi_q.size(), 0);
    tap_size = 16'd1;
    clear_mon();
    busy_dl = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    check_eq("t4_busy_idle", {playing, rd_req, ear}, 3'b000);
    busy_dl = 1'b0;
    tick(2);
    check_eq("t4_busy_no_done", done_cnt, 0);
    pulse_start();
    tick(5);
    busy_dl = 1'b1;
    tick(1);
    busy_dl = 1'b0;
    check_eq("t4_busy_abort", {playing, ear}, 2'b00);
    tick(3);

    // ce every other clock: each half lasts 2*H clocks
    mem[0] = 8'h01;
    tap_size = 16'd1;
    clear_mon();
    ce_mode = 1;
    pulse_start();
    wait_done("t5_done", 400);
    tick(4);
    ce_mode = 0;
    check_eq("t5_pulses", hi_q.size(), 11);
    for (int i = 0; i < 7; i++) check_eq($sformatf("t5_hi%0d", i + 4), hi_q[i + 4], exp5[i]);
    tick(2);

`ifdef TAPE_MOTOR_EN
    mem[0] = 8'h80;
    tap_size = 16'd1;
    clear_mon();
    pulse_start();
    wait_req("tm_req", 100);
    wait_addr_hi("tm_bithi", 16'd0, 20);
    motor = 1'b0;
    tick(50);
    motor = 1'b1;
    wait_done("tm_done", 400);
    tick(4);
    check_eq("tm_pulses", hi_q.size(), 11);
    check_eq("tm_hi_extended", hi_q[3], 54);
    check_eq("tm_hi_next", hi_q[4], 2);
`endif

    // async reset during the leader
    tap_size = 16'd1;
    pulse_start();
    tick(3);
    check_eq("t6_in_leader", playing, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_async_rst", {ear, rd_req, playing, done, rd_addr}, 20'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule
